// File: rtl/ild1420_avg_filter.sv
// ---------------------------------------------------------------------------------------------
// ild1420_avg_filter
//
// Boxcar moving-average filter for decoded ILD1420 laser-sensor samples. Every good sample
// (fresh, error field zero) enters a circular window of N = 2**LOG2_N entries. A running sum
// is maintained incrementally: the new sample is added and the sample it displaces is
// subtracted. Once the window holds N samples, every accepted sample also produces a new
// mean, floor(sum / N), with a one-cycle avg_valid pulse one clock after the sample strobe.
//
// Samples flagged by the sensor (error != 0) are not averaged; they only bump a saturating
// error counter. If no good sample arrives for TIMEOUT_CYCLES clocks, the window is dropped
// and stale is raised. stale then stays high until the next good sample arrives.
//
// Parameters
//   LOG2_N          log2 of window length, legal range 1..6 (so N >= 2)
//   TIMEOUT_CYCLES  clocks without an accepted sample before stale asserts
//
// Ports
//   clk           in   system clock
//   rst_n         in   asynchronous, active-low reset
//   sample_valid  in   1-cycle strobe, new distance/error present
//   distance      in   16-bit unsigned raw distance code
//   error         in   2-bit sensor error field, 2'b00 = good
//   fresh         in   receiver freshness level; samples with fresh=0 are ignored
//   flush         in   synchronous clear of the averaging window (wins over sample_valid)
//   avg_out       out  window mean, floor(sum / N); holds between updates
//   avg_valid     out  1-cycle pulse when avg_out updates
//   window_full   out  level, N samples held since the last clear
//   err_count     out  count of rejected error samples, saturating at 16'hFFFF
//   stale         out  level, no accepted sample within TIMEOUT_CYCLES
// ---------------------------------------------------------------------------------------------
module ild1420_avg_filter #(
    parameter int unsigned LOG2_N         = 3,
    parameter int unsigned TIMEOUT_CYCLES = 60000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [15:0] distance,
    input  logic [1:0]  error,
    input  logic        fresh,
    input  logic        flush,
    output logic [15:0] avg_out,
    output logic        avg_valid,
    output logic        window_full,
    output logic [15:0] err_count,
    output logic        stale
);

    localparam int unsigned N      = 1 << LOG2_N;
    localparam int unsigned SUM_W  = 16 + LOG2_N;
    localparam int unsigned PTR_W  = LOG2_N;
    localparam int unsigned FILL_W = LOG2_N + 1;

    localparam logic [FILL_W-1:0] FILL_MAX     = FILL_W'(N);
    localparam logic [31:0]       TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StEmpty   = 2'd0,
        StFilling = 2'd1,
        StRunning = 2'd2
    } state_e;

    // -----------------------------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------------------------
    state_e             state_q;
    logic [SUM_W-1:0]   sum_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [FILL_W-1:0]  fill_q;
    logic [31:0]        timer_q;

    // Sample storage, deliberately not reset: slots that have not been rewritten since the
    // last clear are masked by fill_q, never by their contents.
    logic [15:0]        buf_mem [N];

    // -----------------------------------------------------------------------------------------
    // Next-state datapath
    // -----------------------------------------------------------------------------------------
    logic               accept;
    logic               reject;
    logic               fill_full;
    logic [15:0]        oldest;
    logic [SUM_W-1:0]   sum_next;
    logic [FILL_W-1:0]  fill_next;
    logic [PTR_W-1:0]   wr_ptr_next;
    logic               full_next;
    logic [15:0]        err_next;
    logic [31:0]        timer_next;
    logic               timeout;

    always_comb begin
        accept      = 1'b0;
        reject      = 1'b0;
        fill_full   = 1'b0;
        oldest      = 16'd0;
        sum_next    = sum_q;
        fill_next   = fill_q;
        wr_ptr_next = wr_ptr_q;
        full_next   = 1'b0;
        err_next    = err_count;
        timer_next  = timer_q;
        timeout     = 1'b0;

        // flush pre-empts any sample in the same cycle, good or bad
        accept = sample_valid & fresh & (error == 2'b00) & ~flush;
        reject = sample_valid & fresh & (error != 2'b00) & ~flush;

        // Only a full window has a sample to retire; before that the slot is treated as 0.
        fill_full = (fill_q == FILL_MAX);
        oldest    = fill_full ? buf_mem[wr_ptr_q] : 16'd0;

        // SUM_W = 16 + LOG2_N bits holds N full-scale samples, so this never wraps.
        sum_next    = sum_q + SUM_W'(distance) - SUM_W'(oldest);
        fill_next   = fill_full ? fill_q : fill_q + FILL_W'(1);
        wr_ptr_next = wr_ptr_q + PTR_W'(1);
        full_next   = (fill_next == FILL_MAX);

        err_next   = (err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
        timer_next = (timer_q != 32'hFFFF_FFFF) ? timer_q + 32'd1 : timer_q;

        // Fires once, on the cycle the idle timer sits at its last allowed value.
        timeout = (timer_q == TIMEOUT_LAST) & ~accept & ~flush;
    end

    // -----------------------------------------------------------------------------------------
    // Control FSM, window bookkeeping and registered outputs
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            sum_q       <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            timer_q     <= '0;
            avg_out     <= 16'd0;
            avg_valid   <= 1'b0;
            window_full <= 1'b0;
            err_count   <= 16'd0;
            stale       <= 1'b1;
        end else begin
            avg_valid <= 1'b0;

            if (flush) begin
                // stale and err_count are deliberately untouched by a flush
                state_q     <= StEmpty;
                sum_q       <= '0;
                wr_ptr_q    <= '0;
                fill_q      <= '0;
                timer_q     <= '0;
                window_full <= 1'b0;
            end else if (accept) begin
                sum_q       <= sum_next;
                wr_ptr_q    <= wr_ptr_next;
                fill_q      <= fill_next;
                timer_q     <= '0;
                stale       <= 1'b0;
                window_full <= full_next;

                unique case (state_q)
                    StEmpty: begin
                        state_q <= full_next ? StRunning : StFilling;
                    end
                    StFilling: begin
                        if (full_next) begin
                            state_q <= StRunning;
                        end
                    end
                    StRunning: begin
                        state_q <= StRunning;
                    end
                    default: begin
                        state_q <= StEmpty;
                    end
                endcase

                if (full_next) begin
                    avg_out   <= sum_next[LOG2_N +: 16];
                    avg_valid <= 1'b1;
                end
            end else begin
                if (reject) begin
                    err_count <= err_next;
                end

                // Loss of data: drop the window but keep the last published mean.
                if (timeout) begin
                    state_q     <= StEmpty;
                    sum_q       <= '0;
                    wr_ptr_q    <= '0;
                    fill_q      <= '0;
                    window_full <= 1'b0;
                    stale       <= 1'b1;
                end

                timer_q <= timer_next;
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Sample buffer write port
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_mem[wr_ptr_q] <= distance;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Invariants
    // -----------------------------------------------------------------------------------------
    a_valid_needs_full : assert property (@(posedge clk) disable iff (!rst_n)
        avg_valid |-> window_full);

    a_full_not_stale : assert property (@(posedge clk) disable iff (!rst_n)
        window_full |-> !stale);

    a_fill_bounded : assert property (@(posedge clk) disable iff (!rst_n)
        fill_q <= FILL_MAX);

    a_full_matches_fsm : assert property (@(posedge clk) disable iff (!rst_n)
        window_full == (state_q == StRunning));

endmodule
